mc_mem_responder: RTL

- Memory-side responder for the multicycle RISC-V core: serves instruction fetches, loads and stores issued by the core's fetch/memory states.
- Unified word-addressed storage behind a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states so the core's states can be stretched against a realistic memory.
- One outstanding transaction at a time.

---
 rtl/mc_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mc_mem_responder.sv
// Memory responder for the multicycle core: one word-addressed array serving fetches, loads and stores.
// Latency: response valid WAIT_CYCLES+2 cycles after accept; backpressure: one transaction in flight, req_ready low until response handshake.
module mc_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     idx;
    logic              acc_err;
    logic              mem_wr;

    // Out-of-range indices are errors rather than aliases of low words.
    assign idx     = addr_q[AW+1:2];
    assign acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign mem_wr  = (state_q == S_ACCESS) && !acc_err && we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                err_d   = acc_err;
                rdata_d = (!acc_err && !we_q) ? mem[idx] : '0;
                cnt_d   = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; an aborted store never reaches ACCESS.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
